// File: rtl/flow_export_scheduler.sv
// Flow-table export scheduler: owns BRAM port B, merges forced exports and an
// aging sweep onto one exporter handshake, and clears every exported entry.
module flow_export_scheduler #(
  parameter int          ADDR_W           = 12,
  parameter int          ENTRY_W          = 241,
  parameter logic [31:0] INACTIVE_TIMEOUT = 32'd15,
  parameter logic [31:0] ACTIVE_TIMEOUT   = 32'd1800,
  parameter logic [15:0] SCAN_INTERVAL    = 16'd64
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [31:0]        now_ts,
  input  logic               scan_enable,
  input  logic               export_now,
  input  logic [ADDR_W-1:0]  export_this,
  output logic               flow_exported_ok,
  output logic               enb,
  output logic               web,
  output logic [ADDR_W-1:0]  addrb,
  output logic [ENTRY_W-1:0] dib,
  input  logic [ENTRY_W-1:0] dob,
  output logic               exp_valid,
  output logic [ADDR_W-1:0]  exp_index,
  output logic [ENTRY_W-1:0] exp_record,
  output logic [1:0]         exp_reason,
  input  logic               exp_ready,
  output logic [31:0]        export_count
);

  typedef enum logic [2:0] {IDLE, RD, CAP, EVAL, CLR, PRESENT, DONE} state_t;

  localparam logic [15:0] IVL_MAX = SCAN_INTERVAL - 16'd1;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W-1:0]  idx;
  logic [15:0]        ivl_cnt;
  logic               forced;
  logic               ok_d;
  logic [1:0]         reason;
  logic [ENTRY_W-1:0] entry;

  logic        guard;
  logic        take_forced;
  logic        take_sweep;
  logic        entry_valid;
  logic [31:0] idle_age;
  logic [31:0] life_age;

  // Entries are only ever cleared from this port.
  assign dib = '0;

  // A forced request is still held high while its completion pulse is seen.
  assign guard       = flow_exported_ok | ok_d;
  assign take_forced = (state == IDLE) && export_now && !guard;
  assign take_sweep  = (state == IDLE) && !take_forced && scan_enable && (ivl_cnt == IVL_MAX);

  assign entry_valid = entry[ENTRY_W-1];
  assign idle_age    = now_ts - entry[95:64];
  assign life_age    = now_ts - entry[127:96];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ivl_cnt <= '0;
    end else if (take_sweep) begin
      ivl_cnt <= '0;
    end else if (ivl_cnt != IVL_MAX) begin
      ivl_cnt <= ivl_cnt + 16'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state            <= IDLE;
      ptr              <= '0;
      idx              <= '0;
      forced           <= 1'b0;
      ok_d             <= 1'b0;
      reason           <= 2'b00;
      entry            <= '0;
      flow_exported_ok <= 1'b0;
      enb              <= 1'b0;
      web              <= 1'b0;
      addrb            <= '0;
      exp_valid        <= 1'b0;
      exp_index        <= '0;
      exp_record       <= '0;
      exp_reason       <= 2'b00;
      export_count     <= '0;
    end else begin
      ok_d <= flow_exported_ok;
      case (state)
        IDLE: begin
          if (take_forced) begin
            forced <= 1'b1;
            idx    <= export_this;
            addrb  <= export_this;
            enb    <= 1'b1;
            state  <= RD;
          end else if (take_sweep) begin
            forced <= 1'b0;
            idx    <= ptr;
            addrb  <= ptr;
            enb    <= 1'b1;
            state  <= RD;
          end
        end
        RD: begin
          enb   <= 1'b0;
          state <= CAP;
        end
        CAP: begin
          entry <= dob;
          state <= EVAL;
        end
        EVAL: begin
          if (forced) begin
            if (entry_valid) begin
              reason <= 2'b11;
              enb    <= 1'b1;
              web    <= 1'b1;
              addrb  <= idx;
              state  <= CLR;
            end else begin
              flow_exported_ok <= 1'b1;
              state            <= DONE;
            end
          end else begin
            ptr <= ptr + 1'b1;
            // Inactivity is checked first so it wins when both limits hold.
            if (entry_valid && idle_age >= INACTIVE_TIMEOUT) begin
              reason <= 2'b01;
              enb    <= 1'b1;
              web    <= 1'b1;
              addrb  <= idx;
              state  <= CLR;
            end else if (entry_valid && life_age >= ACTIVE_TIMEOUT) begin
              reason <= 2'b10;
              enb    <= 1'b1;
              web    <= 1'b1;
              addrb  <= idx;
              state  <= CLR;
            end else begin
              state <= IDLE;
            end
          end
        end
        CLR: begin
          enb        <= 1'b0;
          web        <= 1'b0;
          exp_valid  <= 1'b1;
          exp_index  <= idx;
          exp_record <= entry;
          exp_reason <= reason;
          state      <= PRESENT;
        end
        PRESENT: begin
          if (exp_ready) begin
            exp_valid        <= 1'b0;
            export_count     <= export_count + 32'd1;
            flow_exported_ok <= forced;
            state            <= DONE;
          end
        end
        DONE: begin
          flow_exported_ok <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
